maxpool_unit: RTL
=================

MAXPOOL_UNIT -- requirements
Module: maxpool_unit

Interface
REQ-001 SHALL have parameter IntSize, default 8, pixel width in bits (signed two's complement).
REQ-002 SHALL have parameter PicWidth, default 28, input row length in pixels; even, >=2.
REQ-003 SHALL have parameter PicHeight, default 28, input rows per frame; even, >=2.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins a frame.
REQ-007 SHALL have port in_valid  input  1  upstream conv pixel present.
REQ-008 SHALL have port in_data  input  IntSize  conv pixel, raster order, row-major.
REQ-009 SHALL have port in_ready  output  1  pixel accepted when in_valid && in_ready.
REQ-010 SHALL have port out_valid  output  1  pooled pixel present.
REQ-011 SHALL have port out_data  output  IntSize  pooled pixel, raster order.
REQ-012 SHALL have port out_ready  input  1  pooled pixel consumed when out_valid && out_ready.
REQ-013 SHALL have port done  output  1  one-cycle pulse after the last pooled pixel is consumed.

Function
REQ-014 SHALL use FSM states IDLE, RUN, FLUSH, DONE; reset state IDLE.
REQ-015 IDLE: in_ready=0; start -> RUN, clearing col and row counters.
REQ-016 RUN: in_ready = !out_valid || out_ready; each accepted pixel increments col; col wraps PicWidth-1 -> 0 with row+1.
REQ-017 Even row, even col: SHALL hold pixel in pair register; even row, odd col: SHALL write signed max(pair, pixel) to line buffer entry col/2 (PicWidth/2 entries).
REQ-018 Odd row, even col: SHALL hold pixel in pair register; odd row, odd col: SHALL load out_data with signed max of pair, pixel and line buffer[col/2], asserting out_valid next cycle (latency 1).
REQ-019 Comparison SHALL be signed; equal values yield that value; no saturation or width change.
REQ-020 out_valid SHALL stay high with out_data stable until out_ready; simultaneous pop and new odd-odd acceptance SHALL reload without a bubble.
REQ-021 Acceptance of pixel (PicHeight-1, PicWidth-1) SHALL move RUN -> FLUSH; FLUSH: in_ready=0, stays until the final out_valid is consumed, then -> DONE.
REQ-022 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-023 start outside IDLE SHALL be ignored; in_valid outside RUN SHALL be ignored (not accepted).
REQ-024 Each frame SHALL emit exactly (PicWidth/2)*(PicHeight/2) outputs (196 at defaults).

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, counters 0, in_ready 0, out_valid 0, out_data 0, done 0.
REQ-026 Reset mid-frame SHALL drop the partial frame; line buffer and pair register contents are don't-care and need not be cleared.
REQ-027 First frame after reset release SHALL be correct without any warm-up frame.

Structure
REQ-028 IntSize, picture sizes (784/196/49), and FSM state encodings SHALL live in the shared cnn package used by PE1 and dotProduct.
REQ-029 Line buffer SHALL be a sub-module pool_linebuf (PicWidth/2 x IntSize, one write port, one async read port).
REQ-030 No other sub-modules; counters and FSM SHALL be flat in maxpool_unit.

Verification
REQ-031 4x4 frame, pixels 0..15 in raster order, out_ready=1 -> outputs 5,7,13,15, then done pulse.
REQ-032 28x28 frame all -1 except pixel (27,27)=127 -> 195 outputs of -1, final output 127, done after 196th pop.
REQ-033 4x4 frame -128,-1 mix with signed pattern (row0: -128,-5,3,-2) -> first output max(-128,-5,row1 pair) correct signed result; verify -128 never wins against -1.
REQ-034 out_ready held 0 for 10 cycles after first out_valid -> in_ready low, out_data stable, no pixel lost, final sequence identical to REQ-031.
REQ-035 rst_n low after 100 accepted pixels, then start and full 28x28 ramp -> 196 correct outputs, no stale data from aborted frame.
REQ-036 start pulsed during RUN and in_valid pulsed in IDLE -> no frame restart, no acceptance, output count unchanged.

Source files
------------

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN sizes and pooling FSM state encoding
package cnn_pkg;

   localparam int CnnIntSize     = 8;
   localparam int CnnImgDim      = 28;
   localparam int CnnImgPixels   = 784;
   localparam int CnnPoolPixels  = 196;
   localparam int CnnPool2Pixels = 49;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } pool_state_e;

endpackage

// File: rtl/pool_linebuf.sv
// rtl/pool_linebuf.sv - half-row buffer of horizontal pair maxima, async read
module pool_linebuf #(
   parameter int Depth = 14,
   parameter int Width = 8,
   parameter int AddrW = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AddrW-1:0] waddr,
   input  logic [Width-1:0] wdata,
   input  logic [AddrW-1:0] raddr,
   output logic [Width-1:0] rdata
);

   logic [Width-1:0] mem_q [Depth];

   // Contents need no reset: every entry is written on an even row before it is read.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/maxpool_unit.sv
// rtl/maxpool_unit.sv - streaming 2x2 signed max-pool over a raster frame
module maxpool_unit
   import cnn_pkg::*;
#(
   parameter int IntSize   = CnnIntSize,
   parameter int PicWidth  = CnnImgDim,
   parameter int PicHeight = CnnImgDim
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               in_valid,
   input  logic [IntSize-1:0] in_data,
   output logic               in_ready,
   output logic               out_valid,
   output logic [IntSize-1:0] out_data,
   input  logic               out_ready,
   output logic               done
);

   localparam int ColW    = (PicWidth > 1) ? $clog2(PicWidth) : 1;
   localparam int RowW    = (PicHeight > 1) ? $clog2(PicHeight) : 1;
   localparam int LbDepth = PicWidth / 2;
   localparam int LbAddrW = (LbDepth > 1) ? $clog2(LbDepth) : 1;
   localparam logic [ColW-1:0] ColLast = ColW'(PicWidth - 1);
   localparam logic [RowW-1:0] RowLast = RowW'(PicHeight - 1);

   pool_state_e               state_q;
   logic [ColW-1:0]           col_q;
   logic [RowW-1:0]           row_q;
   logic signed [IntSize-1:0] pair_q;
   logic signed [IntSize-1:0] out_data_q;
   logic                      out_valid_q;
   logic                      done_q;

   logic                      accept;
   logic                      pop;
   logic                      last_pixel;
   logic                      lb_we;
   logic [LbAddrW-1:0]        lb_addr;
   logic signed [IntSize-1:0] lb_rdata;
   logic signed [IntSize-1:0] pair_max;
   logic signed [IntSize-1:0] quad_max;

   function automatic logic signed [IntSize-1:0] smax(input logic signed [IntSize-1:0] a,
                                                      input logic signed [IntSize-1:0] b);
      return (a > b) ? a : b;
   endfunction

   // A held output blocks new pixels unless it is being consumed this cycle.
   assign in_ready   = (state_q == RUN) && (!out_valid_q || out_ready);
   assign accept     = in_valid && in_ready;
   assign pop        = out_valid_q && out_ready;
   assign last_pixel = (row_q == RowLast) && (col_q == ColLast);

   assign lb_addr  = LbAddrW'(col_q >> 1);
   assign pair_max = smax(pair_q, $signed(in_data));
   assign quad_max = smax(pair_max, lb_rdata);
   assign lb_we    = accept && !row_q[0] && col_q[0];

   pool_linebuf #(
      .Depth (LbDepth),
      .Width (IntSize),
      .AddrW (LbAddrW)
   ) u_linebuf (
      .clk   (clk),
      .we    (lb_we),
      .waddr (lb_addr),
      .wdata (pair_max),
      .raddr (lb_addr),
      .rdata (lb_rdata)
   );

   // Frame FSM, raster counters, pair register and registered output slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         col_q       <= '0;
         row_q       <= '0;
         pair_q      <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;

         if (accept && !col_q[0]) begin
            pair_q <= $signed(in_data);
         end

         // Odd-odd pixel completes a window; loading wins over a pop so there is no bubble.
         if (accept && row_q[0] && col_q[0]) begin
            out_data_q  <= quad_max;
            out_valid_q <= 1'b1;
         end else if (pop) begin
            out_valid_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= RUN;
                  col_q   <= '0;
                  row_q   <= '0;
               end
            end
            RUN: begin
               if (accept) begin
                  if (col_q == ColLast) begin
                     col_q <= '0;
                     row_q <= last_pixel ? '0 : row_q + 1'b1;
                  end else begin
                     col_q <= col_q + 1'b1;
                  end
                  if (last_pixel) begin
                     state_q <= FLUSH;
                  end
               end
            end
            FLUSH: begin
               if (!out_valid_q || pop) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign done      = done_q;

endmodule
